// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus REQ/ACK handshake FSM feeding the UART TX shift register.
// Latency: byte written at edge k raises TX_START_REQ after edge k+1; one byte per four-phase handshake.
// Backpressure: writes while FULL are dropped and latch OVERFLOW; the FSM waits indefinitely on TX_START_ACK.

module uart_tx_feeder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_en,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  storage [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_fire;
    logic          rd_fire;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rd_dat = storage[rd_ptr_q];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_comb begin
        wr_fire  = wr_vld && !full;
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            storage[wr_ptr_q] <= wr_dat;
        end
    end
endmodule

module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_START_REQ,
    input  logic                  TX_START_ACK,
    output logic                  BUSY
);
    generate
        if (DEPTH != (1 << ADDR_WIDTH) || DEPTH < 2) begin : g_bad_depth
            $error("uart_tx_feeder: DEPTH must equal 2**ADDR_WIDTH and be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_WAIT = 2'd1,
        ACK_WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  fifo_full;
    logic                  fifo_empty;

    uart_tx_feeder_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_fifo (
        .CLK    (CLK),
        .RST    (RST),
        .wr_vld (WR_EN),
        .wr_dat (WR_DATA),
        .rd_en  (pop),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (COUNT)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        overflow_d = overflow_q || (WR_EN && fifo_full);
        case (state_q)
            IDLE: begin
                // A stray ACK here is ignored; only FIFO occupancy starts a handshake.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_d = head_dat;
                    req_d     = 1'b1;
                    state_d   = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (TX_START_ACK) begin
                    req_d   = 1'b0;
                    state_d = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (!TX_START_ACK) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign FULL         = fifo_full;
    assign EMPTY        = fifo_empty;
    assign OVERFLOW     = overflow_q;
    assign TX_DATA      = tx_data_q;
    assign TX_START_REQ = req_q;
    assign BUSY         = busy_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small TX-controller ACK model.
module tb_uart_tx_feeder;
    logic       CLK;
    logic       RST;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW;
    logic [7:0] TX_DATA;
    logic       TX_START_REQ;
    logic       TX_START_ACK;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    logic       model_en = 1'b0;
    int         ack_lat  = 1;
    int         rel_lat  = 1;
    logic [7:0] cap_q[$];
    int         req_pulses = 0;
    int         req_viol   = 0;
    logic       req_prev   = 1'b0;

    uart_tx_feeder dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR_EN        (WR_EN),
        .WR_DATA      (WR_DATA),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .TX_DATA      (TX_DATA),
        .TX_START_REQ (TX_START_REQ),
        .TX_START_ACK (TX_START_ACK),
        .BUSY         (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered-controller model: ACK rises ack_lat cycles after REQ is seen, falls rel_lat after REQ drops.
    initial begin
        TX_START_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (model_en && TX_START_REQ && !TX_START_ACK) begin
                repeat (ack_lat) @(negedge CLK);
                TX_START_ACK = 1'b1;
                cap_q.push_back(TX_DATA);
                while (TX_START_REQ) @(negedge CLK);
                repeat (rel_lat) @(negedge CLK);
                TX_START_ACK = 1'b0;
            end
        end
    end

    // REQ rising edges, and any rise while the DUT was seeing ACK high.
    always @(posedge CLK) begin
        #1;
        if (TX_START_REQ && !req_prev) begin
            req_pulses++;
            if (TX_START_ACK) req_viol++;
        end
        req_prev = TX_START_REQ;
    end

    task automatic wait_caps(input string tag, input int n, input int budget);
        int i = 0;
        while (cap_q.size() < n && i < budget) begin
            @(negedge CLK);
            i++;
        end
        if (cap_q.size() < n) chk(tag, 32'(cap_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while ((BUSY || TX_START_ACK || !EMPTY) && i < 300) begin
            @(negedge CLK);
            i++;
        end
        if (BUSY || TX_START_ACK || !EMPTY) chk(tag, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        RST     = 1'b1;
        WR_EN   = 1'b0;
        WR_DATA = 8'h00;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        chk("rst_empty",    32'(EMPTY),        32'd1);
        chk("rst_full",     32'(FULL),         32'd0);
        chk("rst_count",    32'(COUNT),        32'd0);
        chk("rst_overflow", 32'(OVERFLOW),     32'd0);
        chk("rst_req",      32'(TX_START_REQ), 32'd0);
        chk("rst_txdata",   32'(TX_DATA),      32'd0);
        chk("rst_busy",     32'(BUSY),         32'd0);

        // Single byte, cycle-exact against the latency table.
        model_en = 1'b1;
        WR_EN = 1'b1; WR_DATA = 8'hA5;
        @(negedge CLK);
        WR_EN = 1'b0;
        chk("s_e0_count", 32'(COUNT),        32'd1);
        chk("s_e0_req",   32'(TX_START_REQ), 32'd0);
        @(negedge CLK);
        chk("s_e1_req",   32'(TX_START_REQ), 32'd1);
        chk("s_e1_data",  32'(TX_DATA),      32'hA5);
        chk("s_e1_count", 32'(COUNT),        32'd0);
        chk("s_e1_busy",  32'(BUSY),         32'd1);
        @(negedge CLK);
        chk("s_e2_req",   32'(TX_START_REQ), 32'd1);
        @(negedge CLK);
        chk("s_e3_req",   32'(TX_START_REQ), 32'd0);
        chk("s_e3_busy",  32'(BUSY),         32'd1);
        @(negedge CLK);
        chk("s_e4_busy",  32'(BUSY),         32'd1);
        @(negedge CLK);
        chk("s_e5_busy",  32'(BUSY),         32'd0);
        chk("s_e5_empty", 32'(EMPTY),        32'd1);
        chk("s_e5_data",  32'(TX_DATA),      32'hA5);
        wait_caps("s_cap_timeout", 1, 20);
        chk("s_cap0", 32'(cap_q[0]), 32'hA5);

        // Back-to-back with a 10-cycle frame.
        wait_idle("b_idle0");
        cap_q.delete();
        ack_lat = 10;
        p0 = req_pulses;
        WR_EN = 1'b1;
        WR_DATA = 8'h11; @(negedge CLK);
        WR_DATA = 8'h22; @(negedge CLK);
        WR_DATA = 8'h33; @(negedge CLK);
        WR_EN = 1'b0;
        wait_caps("b_cap_timeout", 3, 300);
        wait_idle("b_idle1");
        chk("b_cap0",   32'(cap_q[0]), 32'h11);
        chk("b_cap1",   32'(cap_q[1]), 32'h22);
        chk("b_cap2",   32'(cap_q[2]), 32'h33);
        chk("b_pulses", 32'(req_pulses - p0), 32'd3);
        ack_lat = 1;

        // Fill and overflow with the controller stalled.
        model_en = 1'b0;
        cap_q.delete();
        for (int i = 0; i < 18; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(i);
            @(negedge CLK);
        end
        WR_EN = 1'b0;
        chk("f_count",    32'(COUNT),    32'd16);
        chk("f_full",     32'(FULL),     32'd1);
        chk("f_overflow", 32'(OVERFLOW), 32'd1);
        chk("f_txdata",   32'(TX_DATA),  32'h00);
        model_en = 1'b1;
        wait_caps("f_cap_timeout", 17, 400);
        wait_idle("f_idle");
        repeat (5) @(negedge CLK);
        chk("f_ncap", 32'(cap_q.size()), 32'd17);
        for (int i = 0; i < 17 && i < cap_q.size(); i++)
            chk($sformatf("f_cap%0d", i), 32'(cap_q[i]), 32'(i));
        chk("f_overflow_held", 32'(OVERFLOW), 32'd1);
        chk("f_full_after",    32'(FULL),     32'd0);

        // Write lands on the same edge as the pop.
        cap_q.delete();
        WR_EN = 1'b1; WR_DATA = 8'h3C; @(negedge CLK);
        WR_DATA = 8'h7E; @(negedge CLK);
        WR_EN = 1'b0;
        chk("wp_count",  32'(COUNT),        32'd1);
        chk("wp_txdata", 32'(TX_DATA),      32'h3C);
        chk("wp_req",    32'(TX_START_REQ), 32'd1);
        wait_caps("wp_cap_timeout", 2, 100);
        chk("wp_cap0", 32'(cap_q[0]), 32'h3C);
        chk("wp_cap1", 32'(cap_q[1]), 32'h7E);

        // Slow ACK release must block the next pop.
        wait_idle("sa_idle0");
        cap_q.delete();
        rel_lat = 20;
        WR_EN = 1'b1; WR_DATA = 8'h91; @(negedge CLK);
        WR_DATA = 8'h92; @(negedge CLK);
        WR_EN = 1'b0;
        for (int i = 0; i < 50 && (cap_q.size() < 1 || TX_START_REQ); i++) @(negedge CLK);
        repeat (10) @(negedge CLK);
        chk("sa_req",    32'(TX_START_REQ), 32'd0);
        chk("sa_busy",   32'(BUSY),         32'd1);
        chk("sa_count",  32'(COUNT),        32'd1);
        chk("sa_txdata", 32'(TX_DATA),      32'h91);
        wait_caps("sa_cap_timeout", 2, 200);
        chk("sa_cap1", 32'(cap_q[1]), 32'h92);
        wait_idle("sa_idle1");
        rel_lat = 1;

        // Reset in REQ_WAIT with three bytes queued.
        model_en = 1'b0;
        WR_EN = 1'b1;
        WR_DATA = 8'hA1; @(negedge CLK);
        WR_DATA = 8'hA2; @(negedge CLK);
        WR_DATA = 8'hA3; @(negedge CLK);
        WR_DATA = 8'hA4; @(negedge CLK);
        WR_EN = 1'b0;
        chk("r_pre_count", 32'(COUNT),        32'd3);
        chk("r_pre_req",   32'(TX_START_REQ), 32'd1);
        chk("r_pre_ovf",   32'(OVERFLOW),     32'd1);
        RST = 1'b1; @(negedge CLK); RST = 1'b0;
        chk("r_req",      32'(TX_START_REQ), 32'd0);
        chk("r_count",    32'(COUNT),        32'd0);
        chk("r_empty",    32'(EMPTY),        32'd1);
        chk("r_overflow", 32'(OVERFLOW),     32'd0);
        chk("r_busy",     32'(BUSY),         32'd0);
        chk("r_txdata",   32'(TX_DATA),      32'h00);
        model_en = 1'b1;
        cap_q.delete();
        WR_EN = 1'b1; WR_DATA = 8'h5A; @(negedge CLK);
        WR_EN = 1'b0;
        wait_caps("r_cap_timeout", 1, 50);
        chk("r_cap0", 32'(cap_q[0]), 32'h5A);
        wait_idle("r_idle");
        chk("r_end_empty", 32'(EMPTY), 32'd1);

        chk("req_while_ack", 32'(req_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
